cbfp_22: RTL and testbench
==========================

CBFP_22 -- requirements
Module: cbfp_22

Interface
REQ-001 WIDTH, 16, sample width of every input and output lane (re and im).
REQ-002 BLK_CYC, 4, number of valid input beats (16 lanes each) per CBFP block; power of two, 2..32.
REQ-003 MAX_SHIFT, 12, upper clamp on block shift when CBFP_CLAMP_EN is defined; range 0..WIDTH-1.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 din_re[0:15]  input  16x WIDTH signed  upstream butterfly-stage real lanes.
REQ-007 din_im[0:15]  input  16x WIDTH signed  upstream butterfly-stage imaginary lanes.
REQ-008 din_valid  input  1  beat qualifier, driven by the upstream CBFP_valid; gaps allowed.
REQ-009 dout_re[0:15] / dout_im[0:15]  output  16x WIDTH signed  normalized lanes.
REQ-010 dout_valid  output  1  output beat qualifier.
REQ-011 dout_sop  output  1  high on the first output beat of each block.
REQ-012 cbfp_idx  output  5  shift applied to the current output block.

Function
REQ-013 Per-sample redundant-sign count r(x) SHALL be the count of leading bits equal to the MSB, minus 1; range 0..WIDTH-1; x=0 and x=-1 give WIDTH-1.
REQ-014 Block shift s SHALL be the minimum r over all 32*BLK_CYC values (re and im) of the block.
REQ-015 Input beats SHALL be counted only on din_valid; beat count wraps to 0 after BLK_CYC-1, closing the block.
REQ-016 Storage SHALL be ping-pong: two banks of BLK_CYC x 32 words; input writes one bank while the other drains.
REQ-017 Running minimum SHALL be updated per valid beat and latched into the bank's shift register on the closing beat.
REQ-018 Output SHALL start the cycle after the closing input beat and emit BLK_CYC consecutive beats with dout_valid high, in input beat order.
REQ-019 With contiguous input, output beat j SHALL appear exactly BLK_CYC+1 cycles after input beat j.
REQ-020 dout lane = stored lane arithmetically left-shifted by s; no saturation needed, the result never overflows.
REQ-021 cbfp_idx SHALL equal s and be stable for all beats of a block; dout_sop SHALL be high only on beat 0.
REQ-022 Back-to-back blocks SHALL produce back-to-back output with no idle cycle; one bank flips per closing beat.
REQ-023 When dout_valid is low, dout_re, dout_im, dout_sop and cbfp_idx SHALL be driven to 0.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 With rstn low at a clock edge, beat counters, read counter, bank select, bank-full flags, running minimum (reset to WIDTH-1) and all outputs SHALL clear to their idle values; all outputs are 0.
REQ-026 Reset mid-block or mid-drain SHALL discard partial or pending data; the first valid beat after release starts a new block in bank 0.
REQ-027 Bank memories SHALL NOT need reset.

Configuration
REQ-028 Macro CBFP_CLAMP_EN: when defined, s = min(raw minimum, MAX_SHIFT).
REQ-029 When CBFP_CLAMP_EN is undefined, s = raw minimum, MAX_SHIFT is ignored, and no clamp logic is present.

Verification
REQ-030 BLK_CYC=4; all lanes 16'sh0010 for 4 contiguous beats -> from 5 cycles after beat 0, 4 beats of 16'sh4000, cbfp_idx=10, dout_sop on the first beat only.
REQ-031 One lane 16'sh7FFF, others 16'sh0001 -> cbfp_idx=0 and the data passes unchanged.
REQ-032 All-zero block -> cbfp_idx=15 without the macro, and 12 with CBFP_CLAMP_EN; dout all 0.
REQ-033 Three contiguous blocks with distinct minima (r = 3, 7, 0) -> 12 contiguous output beats with cbfp_idx 3, 7, 0 per block and no gap.
REQ-034 Gapped din_valid (high every other cycle) -> output starts the cycle after the 4th valid beat, 4 contiguous beats, with the correct shift.
REQ-035 rstn low for 1 cycle after input beat 2 -> no output for that block; the next 4 beats form a clean block with the correct cbfp_idx.

Source files
------------

// File: rtl/cbfp_22.sv
// rtl/cbfp_22.sv - block-floating-point normalizer between FFT butterfly stages, ping-pong banked
// Optional feature macro: CBFP_CLAMP_EN (clamps the block shift to MAX_SHIFT).
module cbfp_22 #(
  parameter int WIDTH     = 16,
  parameter int BLK_CYC   = 4,
  parameter int MAX_SHIFT = 12
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [WIDTH-1:0] din_re [0:15],
  input  logic signed [WIDTH-1:0] din_im [0:15],
  input  logic                    din_valid,
  output logic signed [WIDTH-1:0] dout_re [0:15],
  output logic signed [WIDTH-1:0] dout_im [0:15],
  output logic                    dout_valid,
  output logic                    dout_sop,
  output logic [4:0]              cbfp_idx
);

  localparam int             CW        = $clog2(BLK_CYC);
  localparam logic [CW-1:0]  LAST_BEAT = CW'(BLK_CYC - 1);
  localparam logic [4:0]     MIN_INIT  = 5'(WIDTH - 1);

  if (BLK_CYC < 2 || BLK_CYC > 32 || (BLK_CYC & (BLK_CYC - 1)) != 0 ||
      MAX_SHIFT < 0 || MAX_SHIFT > WIDTH - 1) begin : g_bad_param
    $error("cbfp_22: illegal parameter value");
  end

  // Redundant sign bits: leading bits equal to the MSB, not counting the MSB itself.
  function automatic logic [4:0] rsc(input logic [WIDTH-1:0] x);
    logic [4:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (run && (x[i] == x[WIDTH-1])) n = n + 5'd1;
      else                             run = 1'b0;
    end
    return n;
  endfunction

  // Ping-pong sample storage; never reset, validity is carried by full_q.
  logic signed [WIDTH-1:0] bank_re_q [2][BLK_CYC][16];
  logic signed [WIDTH-1:0] bank_im_q [2][BLK_CYC][16];

  logic              wr_bank_q;
  logic [CW-1:0]     wr_cnt_q;
  logic [4:0]        min_q;
  logic              rd_bank_q;
  logic [CW-1:0]     rd_cnt_q;
  logic [1:0]        full_q, full_d;
  logic [4:0]        shift_q [2];

  logic signed [WIDTH-1:0] dout_re_q [0:15];
  logic signed [WIDTH-1:0] dout_im_q [0:15];
  logic                    dout_valid_q;
  logic                    dout_sop_q;
  logic [4:0]              cbfp_idx_q;

  logic [4:0] beat_min;
  logic [4:0] blk_shift;
  logic       closing;
  logic       rd_go;
  logic       rd_last;

  assign closing = din_valid && (wr_cnt_q == LAST_BEAT);
  assign rd_go   = full_q[rd_bank_q];
  assign rd_last = rd_go && (rd_cnt_q == LAST_BEAT);

  // Running minimum including the current beat, and the shift it yields on a closing beat.
  always_comb begin
    beat_min = min_q;
    for (int l = 0; l < 16; l++) begin
      if (rsc(din_re[l]) < beat_min) beat_min = rsc(din_re[l]);
      if (rsc(din_im[l]) < beat_min) beat_min = rsc(din_im[l]);
    end
`ifdef CBFP_CLAMP_EN
    blk_shift = (beat_min > 5'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : beat_min;
`else
    blk_shift = beat_min;
`endif
  end

  // Bank-full flags: a closing beat fills the write bank, the last drain beat empties the read bank.
  always_comb begin
    full_d = full_q;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
    if (closing) full_d[wr_bank_q] = 1'b1;
  end

  // Capture each valid beat into the bank currently being filled.
  always_ff @(posedge clk) begin
    if (din_valid) begin
      for (int l = 0; l < 16; l++) begin
        bank_re_q[wr_bank_q][wr_cnt_q][l] <= din_re[l];
        bank_im_q[wr_bank_q][wr_cnt_q][l] <= din_im[l];
      end
    end
  end

  // Write-side block tracking and read-side drain sequencing.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      min_q      <= MIN_INIT;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      full_q     <= '0;
      shift_q[0] <= '0;
      shift_q[1] <= '0;
    end else begin
      full_q <= full_d;
      if (din_valid) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (closing) begin
          min_q              <= MIN_INIT;
          shift_q[wr_bank_q] <= blk_shift;
          wr_bank_q          <= ~wr_bank_q;
        end else begin
          min_q <= beat_min;
        end
      end
      if (rd_go) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
        if (rd_last) rd_bank_q <= ~rd_bank_q;
      end
    end
  end

  // Registered outputs: normalized lanes while draining, all zero otherwise.
  always_ff @(posedge clk) begin
    if (!rstn || !rd_go) begin
      for (int l = 0; l < 16; l++) begin
        dout_re_q[l] <= '0;
        dout_im_q[l] <= '0;
      end
      dout_valid_q <= 1'b0;
      dout_sop_q   <= 1'b0;
      cbfp_idx_q   <= '0;
    end else begin
      for (int l = 0; l < 16; l++) begin
        dout_re_q[l] <= bank_re_q[rd_bank_q][rd_cnt_q][l] <<< shift_q[rd_bank_q];
        dout_im_q[l] <= bank_im_q[rd_bank_q][rd_cnt_q][l] <<< shift_q[rd_bank_q];
      end
      dout_valid_q <= 1'b1;
      dout_sop_q   <= (rd_cnt_q == '0);
      cbfp_idx_q   <= shift_q[rd_bank_q];
    end
  end

  assign dout_re    = dout_re_q;
  assign dout_im    = dout_im_q;
  assign dout_valid = dout_valid_q;
  assign dout_sop   = dout_sop_q;
  assign cbfp_idx   = cbfp_idx_q;

endmodule

// File: tb/tb_cbfp_22.sv
// tb/tb_cbfp_22.sv - directed self-checking bench for cbfp_22
module tb_cbfp_22;

  logic               clk = 1'b0;
  logic               rstn;
  logic signed [15:0] din_re [0:15];
  logic signed [15:0] din_im [0:15];
  logic               din_valid;
  logic signed [15:0] dout_re [0:15];
  logic signed [15:0] dout_im [0:15];
  logic               dout_valid;
  logic               dout_sop;
  logic [4:0]         cbfp_idx;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_cyc    = 0;
  int idle_bad    = 0;

`ifdef CBFP_CLAMP_EN
  localparam logic [4:0] ZERO_IDX = 5'd12;
`else
  localparam logic [4:0] ZERO_IDX = 5'd15;
`endif

  typedef struct packed {
    int          cyc;
    logic [15:0] re0;
    logic [15:0] re3;
    logic [15:0] im15;
    logic        sop;
    logic [4:0]  idx;
  } beat_t;

  beat_t outq[$];

  cbfp_22 #(.WIDTH(16), .BLK_CYC(4), .MAX_SHIFT(12)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .din_re     (din_re),
    .din_im     (din_im),
    .din_valid  (din_valid),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_valid (dout_valid),
    .dout_sop   (dout_sop),
    .cbfp_idx   (cbfp_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t b;
    if (dout_valid === 1'b1) begin
      b.cyc  = cyc;
      b.re0  = dout_re[0];
      b.re3  = dout_re[3];
      b.im15 = dout_im[15];
      b.sop  = dout_sop;
      b.idx  = cbfp_idx;
      outq.push_back(b);
    end else if (dout_valid === 1'b0) begin
      if (dout_sop !== 1'b0 || cbfp_idx !== 5'd0) idle_bad++;
      for (int l = 0; l < 16; l++)
        if (dout_re[l] !== 16'sd0 || dout_im[l] !== 16'sd0) idle_bad++;
    end
  end

  task automatic drive_beat(input logic [15:0] v, input int hot, input logic [15:0] hv);
    @(posedge clk); #1;
    for (int l = 0; l < 16; l++) begin
      din_re[l] = v;
      din_im[l] = v;
    end
    if (hot >= 0) din_re[hot] = hv;
    din_valid = 1'b1;
    last_cyc  = cyc;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (outq.size() < n && t < 40) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
    vectors++; if (dout_sop !== 1'b0) begin miscompares++; $display("FAIL reset_sop got %b exp 0", dout_sop); end
    vectors++; if (cbfp_idx !== 5'd0) begin miscompares++; $display("FAIL reset_idx got %0d exp 0", cbfp_idx); end
    vectors++; if (dout_re[0] !== 16'sd0 || dout_im[15] !== 16'sd0) begin miscompares++; $display("FAIL reset_data got %h/%h exp 0", dout_re[0], dout_im[15]); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    int in0;
    outq.delete();
    for (int j = 0; j < 4; j++) begin
      drive_beat(16'h0010, -1, 16'h0);
      if (j == 0) in0 = last_cyc;
    end
    idle_cycle();
    wait_out(4);
    vectors++; if (outq.size() != 4) begin miscompares++; $display("FAIL basic_count got %0d exp 4", outq.size()); end
    for (int k = 0; k < outq.size() && k < 4; k++) begin
      vectors++; if (outq[k].cyc != in0 + 5 + k) begin miscompares++; $display("FAIL basic_cyc[%0d] got %0d exp %0d", k, outq[k].cyc, in0 + 5 + k); end
      vectors++; if (outq[k].re0 !== 16'h4000 || outq[k].im15 !== 16'h4000) begin miscompares++; $display("FAIL basic_data[%0d] got %h/%h exp 4000", k, outq[k].re0, outq[k].im15); end
      vectors++; if (outq[k].idx !== 5'd10) begin miscompares++; $display("FAIL basic_idx[%0d] got %0d exp 10", k, outq[k].idx); end
      vectors++; if (outq[k].sop !== (k == 0)) begin miscompares++; $display("FAIL basic_sop[%0d] got %b exp %b", k, outq[k].sop, (k == 0)); end
    end
  endtask

  task automatic test_passthru();
    outq.delete();
    for (int j = 0; j < 4; j++) drive_beat(16'h0001, 3, 16'h7FFF);
    idle_cycle();
    wait_out(4);
    vectors++; if (outq.size() != 4) begin miscompares++; $display("FAIL pass_count got %0d exp 4", outq.size()); end
    for (int k = 0; k < outq.size() && k < 4; k++) begin
      vectors++; if (outq[k].idx !== 5'd0) begin miscompares++; $display("FAIL pass_idx[%0d] got %0d exp 0", k, outq[k].idx); end
      vectors++; if (outq[k].re3 !== 16'h7FFF || outq[k].re0 !== 16'h0001 || outq[k].im15 !== 16'h0001) begin miscompares++; $display("FAIL pass_data[%0d] got %h/%h/%h exp 7fff/0001/0001", k, outq[k].re3, outq[k].re0, outq[k].im15); end
    end
  endtask

  task automatic test_zero();
    outq.delete();
    for (int j = 0; j < 4; j++) drive_beat(16'h0000, -1, 16'h0);
    idle_cycle();
    wait_out(4);
    vectors++; if (outq.size() != 4) begin miscompares++; $display("FAIL zero_count got %0d exp 4", outq.size()); end
    for (int k = 0; k < outq.size() && k < 4; k++) begin
      vectors++; if (outq[k].idx !== ZERO_IDX) begin miscompares++; $display("FAIL zero_idx[%0d] got %0d exp %0d", k, outq[k].idx, ZERO_IDX); end
      vectors++; if (outq[k].re0 !== 16'h0 || outq[k].re3 !== 16'h0 || outq[k].im15 !== 16'h0) begin miscompares++; $display("FAIL zero_data[%0d] got %h/%h/%h exp 0", k, outq[k].re0, outq[k].re3, outq[k].im15); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] base    [3] = '{16'h0010, 16'hFFFF, 16'h0001};
    logic [15:0] hot     [3] = '{16'h0800, 16'hFF00, 16'h4000};
    logic [4:0]  exp_idx [3] = '{5'd3, 5'd7, 5'd0};
    logic [15:0] exp_re0 [3] = '{16'h0080, 16'hFF80, 16'h0001};
    logic [15:0] exp_hot [3] = '{16'h4000, 16'h8000, 16'h4000};
    int in0;
    outq.delete();
    for (int blk = 0; blk < 3; blk++)
      for (int j = 0; j < 4; j++) begin
        drive_beat(base[blk], (j == 2) ? 3 : -1, hot[blk]);
        if (blk == 0 && j == 0) in0 = last_cyc;
      end
    idle_cycle();
    wait_out(12);
    vectors++; if (outq.size() != 12) begin miscompares++; $display("FAIL b2b_count got %0d exp 12", outq.size()); end
    for (int k = 0; k < outq.size() && k < 12; k++) begin
      int blk;
      int j;
      blk = k / 4;
      j   = k % 4;
      vectors++; if (outq[k].cyc != in0 + 5 + k) begin miscompares++; $display("FAIL b2b_cyc[%0d] got %0d exp %0d", k, outq[k].cyc, in0 + 5 + k); end
      vectors++; if (outq[k].idx !== exp_idx[blk]) begin miscompares++; $display("FAIL b2b_idx[%0d] got %0d exp %0d", k, outq[k].idx, exp_idx[blk]); end
      vectors++; if (outq[k].sop !== (j == 0)) begin miscompares++; $display("FAIL b2b_sop[%0d] got %b exp %b", k, outq[k].sop, (j == 0)); end
      vectors++; if (outq[k].re0 !== exp_re0[blk] || outq[k].im15 !== exp_re0[blk]) begin miscompares++; $display("FAIL b2b_data[%0d] got %h/%h exp %h", k, outq[k].re0, outq[k].im15, exp_re0[blk]); end
      vectors++; if (outq[k].re3 !== ((j == 2) ? exp_hot[blk] : exp_re0[blk])) begin miscompares++; $display("FAIL b2b_re3[%0d] got %h exp %h", k, outq[k].re3, (j == 2) ? exp_hot[blk] : exp_re0[blk]); end
    end
  endtask

  task automatic test_gapped();
    outq.delete();
    for (int j = 0; j < 4; j++) begin
      drive_beat(16'h0100, -1, 16'h0);
      idle_cycle();
    end
    wait_out(4);
    vectors++; if (outq.size() != 4) begin miscompares++; $display("FAIL gap_count got %0d exp 4", outq.size()); end
    for (int k = 0; k < outq.size() && k < 4; k++) begin
      vectors++; if (outq[k].cyc != last_cyc + 2 + k) begin miscompares++; $display("FAIL gap_cyc[%0d] got %0d exp %0d", k, outq[k].cyc, last_cyc + 2 + k); end
      vectors++; if (outq[k].idx !== 5'd6 || outq[k].re0 !== 16'h4000) begin miscompares++; $display("FAIL gap_out[%0d] got idx %0d data %h exp idx 6 data 4000", k, outq[k].idx, outq[k].re0); end
    end
  endtask

  task automatic test_reset_mid();
    int in0;
    outq.delete();
    for (int j = 0; j < 3; j++) drive_beat(16'h0001, -1, 16'h0);
    @(posedge clk); #1;
    din_valid = 1'b0;
    rstn      = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int j = 0; j < 4; j++) begin
      drive_beat(16'h0040, -1, 16'h0);
      if (j == 0) in0 = last_cyc;
    end
    idle_cycle();
    wait_out(4);
    vectors++; if (outq.size() != 4) begin miscompares++; $display("FAIL rmid_count got %0d exp 4", outq.size()); end
    for (int k = 0; k < outq.size() && k < 4; k++) begin
      vectors++; if (outq[k].cyc != in0 + 5 + k) begin miscompares++; $display("FAIL rmid_cyc[%0d] got %0d exp %0d", k, outq[k].cyc, in0 + 5 + k); end
      vectors++; if (outq[k].idx !== 5'd8 || outq[k].re0 !== 16'h4000) begin miscompares++; $display("FAIL rmid_out[%0d] got idx %0d data %h exp idx 8 data 4000", k, outq[k].idx, outq[k].re0); end
      vectors++; if (outq[k].sop !== (k == 0)) begin miscompares++; $display("FAIL rmid_sop[%0d] got %b exp %b", k, outq[k].sop, (k == 0)); end
    end
  endtask

  task automatic test_idle_zero();
    vectors++; if (idle_bad != 0) begin miscompares++; $display("FAIL idle_zero got %0d nonzero idle outputs exp 0", idle_bad); end
  endtask

  initial begin
    din_valid = 1'b0;
    rstn      = 1'b0;
    for (int l = 0; l < 16; l++) begin
      din_re[l] = '0;
      din_im[l] = '0;
    end
    test_reset();
    test_basic();
    test_passthru();
    test_zero();
    test_back_to_back();
    test_gapped();
    test_reset_mid();
    test_idle_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
